// File: rtl/spi_xfer_arbiter_if.sv
// ---------------------------------------------------------------------------
// spi_xfer_arbiter_if
// Byte-engine bus between spi_xfer_arbiter and a shared spi_master.
//   m_start    arbiter -> engine  1-cycle start pulse
//   m_tx_data  arbiter -> engine  byte to shift out
//   m_cpol     arbiter -> engine  SPI clock polarity
//   m_cpha     arbiter -> engine  SPI clock phase
//   m_tx_ready engine -> arbiter  engine idle, may accept m_start
//   m_done     engine -> arbiter  1-cycle pulse, byte complete
//   m_rx_data  engine -> arbiter  received byte, valid with m_done
// Modports: master = arbiter side, slave = engine side.
// ---------------------------------------------------------------------------
interface spi_xfer_arbiter_if;
  logic       m_start;
  logic [7:0] m_tx_data;
  logic       m_cpol;
  logic       m_cpha;
  logic       m_tx_ready;
  logic       m_done;
  logic [7:0] m_rx_data;

  modport master (
    output m_start, m_tx_data, m_cpol, m_cpha,
    input  m_tx_ready, m_done, m_rx_data
  );

  modport slave (
    input  m_start, m_tx_data, m_cpol, m_cpha,
    output m_tx_ready, m_done, m_rx_data
  );
endinterface

// File: rtl/spi_xfer_arbiter.sv
// ---------------------------------------------------------------------------
// spi_xfer_arbiter
// Round-robin sequencer that runs multi-byte SPI transactions for NUM_REQ
// requesters through one shared spi_master byte engine. Owns the chip
// selects (setup/hold timing) and the per-transaction CPOL/CPHA mode.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   req/req_len/req_cpol/req_cpha/tx_byte   per-requester request side
//   gnt, tx_pop, rx_data, rx_valid, xfer_done, xfer_err  per-requester status
//   CS_n                     active-low chip selects, one per requester
//   m_if (master modport)    byte-engine bus (start/tx/mode/ready/done/rx)
//
// Optional feature: define SPI_ARB_TIMEOUT_EN to add a per-byte watchdog in
// WAIT that aborts the transaction after TIMEOUT_CYC cycles and flags
// xfer_err with xfer_done. Without it, WAIT waits for m_done indefinitely.
// ---------------------------------------------------------------------------
module spi_xfer_arbiter #(
  parameter int NUM_REQ     = 2,
  parameter int LEN_W       = 4,
  parameter int CS_SETUP    = 4,
  parameter int CS_HOLD     = 4,
  parameter int TIMEOUT_CYC = 2048
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*LEN_W-1:0] req_len,
  input  logic [NUM_REQ-1:0]       req_cpol,
  input  logic [NUM_REQ-1:0]       req_cpha,
  input  logic [NUM_REQ*8-1:0]     tx_byte,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [NUM_REQ-1:0]       tx_pop,
  output logic [7:0]               rx_data,
  output logic [NUM_REQ-1:0]       rx_valid,
  output logic [NUM_REQ-1:0]       xfer_done,
  output logic [NUM_REQ-1:0]       xfer_err,
  output logic [NUM_REQ-1:0]       CS_n,
  spi_xfer_arbiter_if.master       m_if
);

  localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_MAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_START = 3'd2,
    ST_WAIT  = 3'd3,
    ST_HOLD  = 3'd4
  } state_t;

  // First set request at or after ptr, wrapping modulo NUM_REQ.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                               input logic [IDX_W-1:0]   ptr);
    logic [IDX_W-1:0]   sel;
    logic               found;
    logic [NUM_REQ-1:0] sh;
    int                 idx;
    sel   = ptr;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(ptr) + i) % NUM_REQ;
      sh  = r >> idx;
      if (!found && sh[0]) begin
        sel   = IDX_W'(idx);
        found = 1'b1;
      end else begin
        found = found;
      end
    end
    return sel;
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] i);
    return NUM_REQ'(1) << i;
  endfunction

  function automatic logic [IDX_W-1:0] rr_next(input logic [IDX_W-1:0] g);
    return (int'(g) == NUM_REQ - 1) ? IDX_W'(0) : g + IDX_W'(1);
  endfunction

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d, cs_n_q, cs_n_d;
  logic [IDX_W-1:0]   g_q, g_d, rr_q, rr_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               cpol_q, cpol_d, cpha_q, cpha_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_REQ-1:0] tx_pop_q, tx_pop_d, rx_valid_q, rx_valid_d;
  logic [NUM_REQ-1:0] xfer_done_q, xfer_done_d;
  logic [7:0]         rx_data_q, rx_data_d, m_tx_data_q, m_tx_data_d;
  logic               m_start_q, m_start_d;
  logic [IDX_W-1:0]   pick_s;
  logic [LEN_W-1:0]   pick_len_s;

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  logic [WD_W-1:0]    wd_q, wd_d;
  logic               err_q, err_d;
  logic [NUM_REQ-1:0] xfer_err_q, xfer_err_d;
`else
  localparam int timeout_unused = TIMEOUT_CYC;
`endif

  // Arbitration winner and its requested length for the IDLE grant decision.
  always_comb begin
    pick_s     = rr_pick(req, rr_q);
    pick_len_s = req_len[int'(pick_s)*LEN_W +: LEN_W];
  end

  // Next-state and output logic of the transaction FSM.
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    cs_n_d      = cs_n_q;
    g_d         = g_q;
    rr_d        = rr_q;
    len_d       = len_q;
    cpol_d      = cpol_q;
    cpha_d      = cpha_q;
    cnt_d       = cnt_q;
    rx_data_d   = rx_data_q;
    m_tx_data_d = m_tx_data_q;
    m_start_d   = 1'b0;
    tx_pop_d    = '0;
    rx_valid_d  = '0;
    xfer_done_d = '0;
`ifdef SPI_ARB_TIMEOUT_EN
    wd_d        = wd_q;
    err_d       = err_q;
    xfer_err_d  = '0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          g_d     = pick_s;
          gnt_d   = onehot(pick_s);
          cs_n_d  = ~onehot(pick_s);
          // A zero length still moves one byte.
          len_d   = (pick_len_s == '0) ? LEN_W'(1) : pick_len_s;
          cpol_d  = req_cpol[pick_s];
          cpha_d  = req_cpha[pick_s];
          cnt_d   = CNT_W'(CS_SETUP - 1);
`ifdef SPI_ARB_TIMEOUT_EN
          err_d   = 1'b0;
`endif
          state_d = ST_SETUP;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETUP: begin
        if (cnt_q == '0) begin
          state_d = ST_START;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_START: begin
        if (m_if.m_tx_ready) begin
          m_start_d   = 1'b1;
          m_tx_data_d = tx_byte[int'(g_q)*8 +: 8];
          tx_pop_d    = onehot(g_q);
`ifdef SPI_ARB_TIMEOUT_EN
          wd_d        = '0;
`endif
          state_d     = ST_WAIT;
        end else begin
          state_d = ST_START;
        end
      end
      ST_WAIT: begin
        if (m_if.m_done) begin
          rx_data_d  = m_if.m_rx_data;
          rx_valid_d = onehot(g_q);
          len_d      = len_q - LEN_W'(1);
          if (len_q == LEN_W'(1)) begin
            cnt_d   = CNT_W'(CS_HOLD - 1);
            state_d = ST_HOLD;
          end else begin
            state_d = ST_START;
          end
        end
`ifdef SPI_ARB_TIMEOUT_EN
        else if (wd_q == WD_W'(TIMEOUT_CYC - 1)) begin
          // Engine stuck: drop the remaining bytes and close the frame.
          err_d   = 1'b1;
          cnt_d   = CNT_W'(CS_HOLD - 1);
          state_d = ST_HOLD;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
`else
        else begin
          state_d = ST_WAIT;
        end
`endif
      end
      ST_HOLD: begin
        if (cnt_q == '0) begin
          cs_n_d      = '1;
          gnt_d       = '0;
          xfer_done_d = onehot(g_q);
`ifdef SPI_ARB_TIMEOUT_EN
          xfer_err_d  = err_q ? onehot(g_q) : '0;
`endif
          // Advance past the winner so other pending requesters go first.
          rr_d        = rr_next(g_q);
          state_d     = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        cs_n_d  = '1;
        gnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM state and registered outputs; reset releases all chip selects at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      gnt_q       <= '0;
      cs_n_q      <= '1;
      g_q         <= '0;
      rr_q        <= '0;
      len_q       <= '0;
      cpol_q      <= 1'b0;
      cpha_q      <= 1'b0;
      cnt_q       <= '0;
      rx_data_q   <= 8'h00;
      m_tx_data_q <= 8'h00;
      m_start_q   <= 1'b0;
      tx_pop_q    <= '0;
      rx_valid_q  <= '0;
      xfer_done_q <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      cs_n_q      <= cs_n_d;
      g_q         <= g_d;
      rr_q        <= rr_d;
      len_q       <= len_d;
      cpol_q      <= cpol_d;
      cpha_q      <= cpha_d;
      cnt_q       <= cnt_d;
      rx_data_q   <= rx_data_d;
      m_tx_data_q <= m_tx_data_d;
      m_start_q   <= m_start_d;
      tx_pop_q    <= tx_pop_d;
      rx_valid_q  <= rx_valid_d;
      xfer_done_q <= xfer_done_d;
    end
  end

`ifdef SPI_ARB_TIMEOUT_EN
  // Watchdog counter, abort flag and error pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_q       <= '0;
      err_q      <= 1'b0;
      xfer_err_q <= '0;
    end else begin
      wd_q       <= wd_d;
      err_q      <= err_d;
      xfer_err_q <= xfer_err_d;
    end
  end
  assign xfer_err = xfer_err_q;
`else
  assign xfer_err = '0;
`endif

  assign gnt       = gnt_q;
  assign CS_n      = cs_n_q;
  assign tx_pop    = tx_pop_q;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign xfer_done = xfer_done_q;

  // Mode comes from the grant-time latch and is simply held through IDLE.
  assign m_if.m_start   = m_start_q;
  assign m_if.m_tx_data = m_tx_data_q;
  assign m_if.m_cpol    = cpol_q;
  assign m_if.m_cpha    = cpha_q;

endmodule
